// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: valid/ready FIFO controller over dual_port_RAM (port 1 write, port 2 read); DPRAM_FIFO_LEVEL_EN adds level/almost_full
module dpram_fifo_ctrl #(
  parameter int data_width = 8,
  parameter int addr_width = 10,
  parameter int af_thresh = 2**addr_width - 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [data_width-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [data_width-1:0] rd_data,
  input  logic                  rd_ready,
  output logic [addr_width-1:0] ram_addr_in1,
  output logic [data_width-1:0] ram_data_in1,
  output logic                  ram_wr_en1,
  output logic [addr_width-1:0] ram_addr_in2,
  output logic [data_width-1:0] ram_data_in2,
  output logic                  ram_wr_en2,
  input  logic [data_width-1:0] ram_data_out2
`ifdef DPRAM_FIFO_LEVEL_EN
  ,
  output logic [addr_width:0]   level,
  output logic                  almost_full
`endif
);
  localparam logic [addr_width:0] depth = {1'b1, {addr_width{1'b0}}};
  logic [addr_width-1:0] wr_ptr, rd_ptr;
  logic [addr_width:0] count, count_nxt;
  logic push, pop, full;
  assign full = count == depth;
  assign wr_ready = !full;
  assign push = wr_valid & wr_ready;
  assign pop = rd_valid & rd_ready;
  assign count_nxt = count + (addr_width+1)'(push) - (addr_width+1)'(pop);
  assign ram_addr_in1 = wr_ptr;
  assign ram_data_in1 = wr_data;
  assign ram_wr_en1 = push;
  // read the post-edge head so the registered RAM output lines up with rd_valid
  assign ram_addr_in2 = rd_ptr + addr_width'(pop);
  assign ram_data_in2 = '0;
  assign ram_wr_en2 = 1'b0;
  assign rd_data = ram_data_out2;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rd_valid <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + addr_width'(push);
      rd_ptr <= rd_ptr + addr_width'(pop);
      count <= count_nxt;
      // this edge's push is excluded: the RAM is read-before-write on collision
      rd_valid <= count > (addr_width+1)'(pop);
    end
  end
`ifdef DPRAM_FIFO_LEVEL_EN
  assign level = count;
  always_ff @(posedge clk) begin
    if (rst) almost_full <= 1'b0;
    else almost_full <= count_nxt >= (addr_width+1)'(af_thresh);
  end
`else
  logic unused_af;
  assign unused_af = af_thresh != 0;
`endif
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl: scoreboard bench for dpram_fifo_ctrl with a read-before-write dual-port RAM model
module tb_dpram_fifo_ctrl;
  localparam int dw = 8;
  localparam int aw = 10;
  localparam int depth = 1 << aw;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_valid = 1'b0;
  logic [dw-1:0] wr_data = '0;
  logic rd_ready = 1'b0;
  logic wr_ready, rd_valid, ram_wr_en1, ram_wr_en2;
  logic [dw-1:0] rd_data, ram_data_in1, ram_data_in2;
  logic [dw-1:0] ram_out = '0;
  logic [aw-1:0] ram_addr_in1, ram_addr_in2;
`ifdef DPRAM_FIFO_LEVEL_EN
  logic [aw:0] level;
  logic almost_full;
`endif
  logic [dw-1:0] mem [depth];
  int tests = 0;
  int fails = 0;
  logic [dw-1:0] mq [$];
  bit pend = 0;
  bit m_rv = 0;
  bit m_af = 0;
  bit armed = 0;
  int m_wptr = 0;

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.data_width(dw), .addr_width(aw), .af_thresh(4)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .ram_addr_in1(ram_addr_in1), .ram_data_in1(ram_data_in1), .ram_wr_en1(ram_wr_en1),
    .ram_addr_in2(ram_addr_in2), .ram_data_in2(ram_data_in2), .ram_wr_en2(ram_wr_en2),
    .ram_data_out2(ram_out)
`ifdef DPRAM_FIFO_LEVEL_EN
    , .level(level), .almost_full(almost_full)
`endif
  );

  always @(posedge clk) begin
    ram_out <= mem[ram_addr_in2];
    if (ram_wr_en1) mem[ram_addr_in1] <= ram_data_in1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected words are queued by the stimulus when a push is issued into a non-full FIFO.
  task automatic step(input bit v, input logic [dw-1:0] d, input bit r);
    wr_valid = v;
    wr_data = d;
    rd_ready = r;
    pend = 0;
    if (!rst && v && mq.size() < depth) begin
      mq.push_back(d);
      pend = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < depth + 20 && mq.size() > 0; i++) step(0, '0, 1);
    if (mq.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d words left, required 0", mq.size());
    end
    step(0, '0, 0);
  endtask

  always @(negedge clk) begin
    int size_pre;
    bit pop;
    size_pre = mq.size() - int'(pend);
    pop = m_rv && rd_ready;
    if (armed) begin
      chk("rd_valid", rd_valid, m_rv);
      chk("wr_ready", wr_ready, size_pre < depth);
      chk("ram_wr_en1", ram_wr_en1, wr_valid && size_pre < depth);
      chk("ram_port2_idle", {ram_wr_en2, ram_data_in2}, 0);
      if (ram_wr_en1) begin
        chk("ram_addr_in1", ram_addr_in1, m_wptr % depth);
        chk("ram_data_in1", ram_data_in1, wr_data);
      end
      if (m_rv) chk("rd_data", rd_data, mq[0]);
`ifdef DPRAM_FIFO_LEVEL_EN
      chk("level", level, size_pre);
      chk("almost_full", almost_full, m_af);
`endif
    end
    if (rst) begin
      mq.delete();
      m_rv = 0;
      m_af = 0;
      m_wptr = 0;
      armed = 1;
    end else if (armed) begin
      m_rv = (size_pre - int'(pop)) > 0;
      if (pop) void'(mq.pop_front());
      if (pend) m_wptr++;
      m_af = mq.size() >= 4;
    end
    pend = 0;
  end

  initial begin
    step(0, '0, 0);
    step(0, '0, 0);
    rst = 0;
    step(0, '0, 0);
    step(1, 8'h11, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 0);
    drain();
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 0);
    drain();
    for (int i = 0; i < depth; i++) step(1, 8'($urandom), 0);
    step(1, 8'hEE, 0);
    step(1, 8'hEE, 1);
    drain();
    for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0);
    step(0, '0, 0);
    for (int i = 0; i < 2000; i++) step(1, 8'($urandom), 1);
    drain();
    step(1, 8'h33, 0);
    step(0, '0, 0);
    step(1, 8'h5A, 1);
    step(0, '0, 0);
    step(0, '0, 0);
    drain();
    for (int i = 0; i < 7; i++) step(1, 8'(8'h70 + i), 0);
    step(0, '0, 0);
    rst = 1;
    step(1, 8'h99, 1);
    rst = 0;
    step(0, '0, 0);
    step(0, '0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ((i / 500) % 2 == 0) step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0);
      else step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
